alu_mux: RTL and testbench
==========================

// Module: alu_mux
// PURPOSE
//   Execute-stage ALU operand-B selector for the 32-bit RV32 core.
//   Picks between register-file read data (wd) and the sign-extended immediate (ImmExt) under ALUSrc.
//   Drives the ALU combinationally on B_out.
//   Also registers the selected operand and the rs2 store data into the EX/MEM boundary.
// PARAMETERS
//   XLEN     32   datapath width of all data ports
// PORTS
//   Clocking: one clock; reset is asynchronous and active-low.
//   clk          in   1     rising-edge clock
//   rst_n        in   1     async active-low reset
//   wd           in   XLEN  register-file read data 2 (rs2)
//   ImmExt       in   XLEN  sign-extended immediate
//   ALUSrc       in   1     0: select rs2 path, 1: select ImmExt
//   fwd_sel      in   2     rs2 forwarding select (used only with ALU_MUX_FWD_EN)
//   fwd_mem      in   XLEN  forwarded EX/MEM result
//   fwd_wb       in   XLEN  forwarded MEM/WB result
//   in_valid     in   1     instruction in EX is valid
//   stall        in   1     hold pipeline register
//   flush        in   1     kill instruction entering EX/MEM
//   B_out        out  XLEN  combinational ALU operand B
//   B_q          out  XLEN  registered operand B
//   store_q      out  XLEN  registered rs2 value (store data, never the immediate)
//   valid_q      out  1     registered valid
// BEHAVIOUR
//   - rs2_sel (internal) is wd unless forwarding is compiled in (see CONFIGURATION).
//   - B_out = ALUSrc ? ImmExt : rs2_sel.
//     - Purely combinational, zero latency, no clock or reset dependence.
//     - All 32 bits pass unmodified; no extension or truncation.
//   - Reset (rst_n low, asynchronous):
//     - B_q = 0, store_q = 0, valid_q = 0 immediately.
//     - B_out is unaffected by reset.
//   - Each rising clk edge, with rst_n high, priority is flush > stall > load:
//     - flush = 1: valid_q <= 0. B_q and store_q load if stall = 0 and hold if stall = 1.
//     - stall = 1 (no flush): all registers hold.
//     - Otherwise: B_q <= B_out, store_q <= rs2_sel, valid_q <= in_valid.
//   - Reset deassertion: registers stay 0 until the first qualifying edge.
//   - B_q and store_q load even when in_valid = 0 (data is don't-care, valid_q gates it).
// CONFIGURATION
//   ALU_MUX_FWD_EN defined:
//     - rs2_sel from fwd_sel: 2'b00 wd, 2'b01 fwd_wb, 2'b10 fwd_mem, 2'b11 wd (reserved).
//     - Forwarding applies to both B_out (when ALUSrc = 0) and store_q.
//   ALU_MUX_FWD_EN undefined:
//     - rs2_sel = wd.
//     - fwd_sel, fwd_mem and fwd_wb remain as ports but are ignored.
// TESTING
//   1. wd=0x0000000A, ImmExt=0xFFFFFFF6, ALUSrc=0 -> B_out=0x0000000A within 1 time unit, no clock.
//   2. Same operands, ALUSrc=1 -> B_out=0xFFFFFFF6.
//      Repeat with wd=0x00001234, ImmExt=0x00001000: ALUSrc=0 -> 0x00001234, ALUSrc=1 -> 0x00001000.
//   3. Assert rst_n=0 mid-cycle after loading nonzero data -> B_q, store_q, valid_q = 0 without a clock edge.
//   4. ALUSrc=1, wd=0x1234, ImmExt=0x1000, in_valid=1, then clock -> B_q=0x1000, store_q=0x1234, valid_q=1.
//      Then stall=1 with new inputs -> outputs hold. Then flush=1 -> valid_q=0.
//   5. With ALU_MUX_FWD_EN: ALUSrc=0, fwd_sel=2'b10, fwd_mem=0xDEADBEEF -> B_out=0xDEADBEEF.
//      fwd_sel=2'b11 -> B_out=wd.
//      Without the macro, the same stimulus -> B_out=wd.

Source files
------------

// File: rtl/alu_mux.sv
// Execute-stage ALU operand-B selector with EX/MEM pipeline registers for the RV32 core.
// Optional rs2 forwarding is compiled in with `define ALU_MUX_FWD_EN.
module alu_mux #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] wd,
  input  logic [XLEN-1:0] ImmExt,
  input  logic            ALUSrc,
  input  logic [1:0]      fwd_sel,
  input  logic [XLEN-1:0] fwd_mem,
  input  logic [XLEN-1:0] fwd_wb,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] B_out,
  output logic [XLEN-1:0] B_q,
  output logic [XLEN-1:0] store_q,
  output logic            valid_q
);

  logic [XLEN-1:0] rs2_sel;

`ifdef ALU_MUX_FWD_EN
  // 2'b11 is reserved and falls back to the register-file value.
  always_comb begin
    // NOTE: default assignment first so every path drives rs2_sel and no latch is inferred.
    rs2_sel = wd;
    unique case (fwd_sel)
      2'b01:   rs2_sel = fwd_wb;
      2'b10:   rs2_sel = fwd_mem;
      default: rs2_sel = wd;
    endcase
  end
`else
  assign rs2_sel = wd;

  // Forwarding ports stay on the interface so both builds share one pin-out.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_sel, fwd_mem, fwd_wb};
`endif

  assign B_out = ALUSrc ? ImmExt : rs2_sel;

  // Flush kills valid but lets data move unless stalled; stall alone freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rst_n) begin
      B_q     <= '0;
      store_q <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      if (!stall) begin
        B_q     <= B_out;
        store_q <= rs2_sel;
      end
    end else if (!stall) begin
      B_q     <= B_out;
      store_q <= rs2_sel;
      valid_q <= in_valid;
    end
  end

endmodule

// File: tb/tb_alu_mux.sv
// Self-checking bench for alu_mux: directed operand/pipeline scenarios plus a
// randomised scoreboard run; expectations are queued at drive time and popped at sampling.
module tb_alu_mux;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] store;
    logic            valid;
  } reg_exp_t;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] wd, ImmExt, fwd_mem, fwd_wb;
  logic            ALUSrc, in_valid, stall, flush;
  logic [1:0]      fwd_sel;
  logic [XLEN-1:0] B_out, B_q, store_q;
  logic            valid_q;

  logic [XLEN-1:0] comb_q [$];
  reg_exp_t        reg_q  [$];

  // Reference view of the pipeline registers.
  logic [XLEN-1:0] m_b, m_store;
  logic            m_valid;

  int vectors;
  int miscompares;

  alu_mux #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wd       (wd),
    .ImmExt   (ImmExt),
    .ALUSrc   (ALUSrc),
    .fwd_sel  (fwd_sel),
    .fwd_mem  (fwd_mem),
    .fwd_wb   (fwd_wb),
    .in_valid (in_valid),
    .stall    (stall),
    .flush    (flush),
    .B_out    (B_out),
    .B_q      (B_q),
    .store_q  (store_q),
    .valid_q  (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [XLEN-1:0] rs2_model(logic [1:0] sel, logic [XLEN-1:0] w,
                                                logic [XLEN-1:0] mem, logic [XLEN-1:0] wb);
`ifdef ALU_MUX_FWD_EN
    case (sel)
      2'b01:   return wb;
      2'b10:   return mem;
      default: return w;
    endcase
`else
    return w;
`endif
  endfunction

  task automatic drive(logic [XLEN-1:0] w, logic [XLEN-1:0] imm, logic src,
                       logic v, logic st, logic fl);
    wd = w; ImmExt = imm; ALUSrc = src; in_valid = v; stall = st; flush = fl;
  endtask

  task automatic check_comb(string nm, logic [XLEN-1:0] exp_b);
    logic [XLEN-1:0] e;
    comb_q.push_back(exp_b);
    #1;
    e = comb_q.pop_front();
    vectors++;
    if (B_out !== e) begin
      miscompares++;
      $display("FAIL %s: B_out got 0x%08h, required 0x%08h", nm, B_out, e);
    end
  endtask

  task automatic check_regs(string nm);
    reg_exp_t e;
    e = reg_q.pop_front();
    vectors++;
    if (B_q !== e.b || store_q !== e.store || valid_q !== e.valid) begin
      miscompares++;
      $display("FAIL %s: got B_q=0x%08h store_q=0x%08h valid_q=%b, required B_q=0x%08h store_q=0x%08h valid_q=%b",
               nm, B_q, store_q, valid_q, e.b, e.store, e.valid);
    end
  endtask

  // Predict the post-edge register state from the current inputs, clock once, compare.
  task automatic step(string nm);
    logic [XLEN-1:0] rs2, bsel;
    reg_exp_t n;
    rs2  = rs2_model(fwd_sel, wd, fwd_mem, fwd_wb);
    bsel = ALUSrc ? ImmExt : rs2;
    n = '{b: m_b, store: m_store, valid: m_valid};
    if (flush) begin
      n.valid = 1'b0;
      if (!stall) begin n.b = bsel; n.store = rs2; end
    end else if (!stall) begin
      n.b = bsel; n.store = rs2; n.valid = in_valid;
    end
    reg_q.push_back(n);
    @(posedge clk);
    m_b = n.b; m_store = n.store; m_valid = n.valid;
    #1;
    check_regs(nm);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reg_exp_t z;
    z = '0;
    rst_n = 1'b0;
    drive(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    fwd_sel = 2'b00; fwd_mem = '0; fwd_wb = '0;
    m_b = '0; m_store = '0; m_valid = 1'b0;
    repeat (2) @(negedge clk);
    reg_q.push_back(z);
    #1;
    check_regs("reset_state");
    rst_n = 1'b1;
    reg_q.push_back(z);
    #1;
    check_regs("reset_release_holds_zero");
    @(negedge clk);
  endtask

  task automatic test_comb();
    @(negedge clk);
    stall = 1'b1;
    drive(32'h0000_000A, 32'hFFFF_FFF6, 1'b0, 1'b0, 1'b1, 1'b0);
    check_comb("comb_rs2_small", 32'h0000_000A);
    ALUSrc = 1'b1;
    check_comb("comb_imm_negative", 32'hFFFF_FFF6);
    drive(32'h0000_1234, 32'h0000_1000, 1'b0, 1'b0, 1'b1, 1'b0);
    check_comb("comb_rs2_1234", 32'h0000_1234);
    ALUSrc = 1'b1;
    check_comb("comb_imm_1000", 32'h0000_1000);
    drive(32'h8000_0001, 32'h7FFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    check_comb("comb_rs2_msb_lsb", 32'h8000_0001);
    step("stall_after_reset_keeps_zero");
  endtask

  task automatic test_pipeline();
    drive(32'h0000_1234, 32'h0000_1000, 1'b1, 1'b1, 1'b0, 1'b0);
    step("load_imm_select");
    drive(32'hCAFE_0000, 32'h0BAD_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step("stall_holds");
    drive(32'h1111_2222, 32'h3333_4444, 1'b0, 1'b1, 1'b1, 1'b1);
    step("flush_with_stall_holds_data");
    drive(32'h0000_1234, 32'h0000_1000, 1'b1, 1'b1, 1'b0, 1'b0);
    step("reload");
    drive(32'h5555_AAAA, 32'h0F0F_0F0F, 1'b0, 1'b1, 1'b0, 1'b1);
    step("flush_loads_data_kills_valid");
    drive(32'h1357_9BDF, 32'h2468_ACE0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("invalid_still_loads_data");
  endtask

  task automatic test_async_reset();
    drive(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b1, 1'b0, 1'b0);
    step("load_before_reset");
    #2;
    rst_n = 1'b0;
    m_b = '0; m_store = '0; m_valid = 1'b0;
    reg_q.push_back('0);
    #1;
    check_regs("async_reset_midcycle");
    check_comb("reset_leaves_B_out", 32'hA5A5_A5A5);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fwd();
    drive(32'h0000_0055, 32'h0000_0F00, 1'b0, 1'b1, 1'b0, 1'b0);
    fwd_sel = 2'b10; fwd_mem = 32'hDEAD_BEEF; fwd_wb = 32'h0BAD_F00D;
`ifdef ALU_MUX_FWD_EN
    check_comb("fwd_mem_select", 32'hDEAD_BEEF);
    fwd_sel = 2'b01;
    check_comb("fwd_wb_select", 32'h0BAD_F00D);
`else
    check_comb("fwd_ignored_mem", 32'h0000_0055);
    fwd_sel = 2'b01;
    check_comb("fwd_ignored_wb", 32'h0000_0055);
`endif
    step("fwd_store_path");
    fwd_sel = 2'b11;
    check_comb("fwd_reserved_is_wd", 32'h0000_0055);
    ALUSrc = 1'b1; fwd_sel = 2'b10;
    check_comb("fwd_imm_overrides", 32'h0000_0F00);
    step("fwd_imm_store_rs2");
    fwd_sel = 2'b00;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      wd       = $urandom;
      ImmExt   = $urandom;
      fwd_mem  = $urandom;
      fwd_wb   = $urandom;
      fwd_sel  = 2'($urandom_range(0, 3));
      ALUSrc   = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 4) == 0);
      check_comb("random_comb", ALUSrc ? ImmExt : rs2_model(fwd_sel, wd, fwd_mem, fwd_wb));
      step("random_regs");
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_comb();
    test_pipeline();
    test_async_reset();
    test_fwd();
    test_back_to_back();
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, required 0/0",
               comb_q.size(), reg_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
